mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit in the execute stage, beside the ALU.
//  It takes the same SrcA/SrcB operands and implements MULT, MULTU, DIV and DIVU.

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the execute stage and the iterative multiply/divide unit.
// The pipeline drives the request side as master; the unit answers as slave.
interface mult_div_unit_if #(
    parameter int width = 32
);
    logic             start;
    logic [1:0]       MDControl;
    logic [width-1:0] SrcA;
    logic [width-1:0] SrcB;
    logic [width-1:0] HI;
    logic [width-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, MDControl, SrcA, SrcB,
        input  HI, LO, busy, done, div_zero
    );

    modport slave (
        input  start, MDControl, SrcA, SrcB,
        output HI, LO, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit (MULTU, MULT, DIVU, DIV) with architectural HI/LO.
// Works on operand magnitudes for width cycles, then applies the sign fix in one extra cycle.
module mult_div_unit #(
    parameter int width = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(width) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    function automatic logic [width-1:0] neg_w(input logic [width-1:0] v);
        neg_w = ~v + {{(width-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*width-1:0] neg_2w(input logic [2*width-1:0] v);
        neg_2w = ~v + {{(2*width-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_r, state_s;
    logic               is_div_r, is_div_s;
    logic               sign_q_r, sign_q_s;
    logic               sign_rem_r, sign_rem_s;
    logic [width-1:0]   op_r, op_s;
    logic [width-1:0]   a_raw_r, a_raw_s;
    logic [2*width-1:0] acc_r, acc_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [width-1:0]   hi_r, hi_s;
    logic [width-1:0]   lo_r, lo_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               dz_r, dz_s;

    logic               sa_s, sb_s;
    logic [width-1:0]   a_mag_s, b_mag_s;
    logic [width:0]     mul_sum_s;
    logic [width:0]     div_shift_s;
    logic [width-1:0]   div_diff_s;
    logic               div_ge_s;

    assign sa_s    = bus.MDControl[0] & bus.SrcA[width-1];
    assign sb_s    = bus.MDControl[0] & bus.SrcB[width-1];
    assign a_mag_s = sa_s ? neg_w(bus.SrcA) : bus.SrcA;
    assign b_mag_s = sb_s ? neg_w(bus.SrcB) : bus.SrcB;

    // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
    assign mul_sum_s   = {1'b0, acc_r[2*width-1:width]} + (acc_r[0] ? {1'b0, op_r} : {(width+1){1'b0}});
    assign div_shift_s = {acc_r[2*width-1:width], acc_r[width-1]};
    assign div_ge_s    = div_shift_s >= {1'b0, op_r};
    assign div_diff_s  = div_shift_s[width-1:0] - op_r;

    // Next-state and datapath update for IDLE/CALC/FIX
    always_comb begin
        state_s    = state_r;
        is_div_s   = is_div_r;
        sign_q_s   = sign_q_r;
        sign_rem_s = sign_rem_r;
        op_s       = op_r;
        a_raw_s    = a_raw_r;
        acc_s      = acc_r;
        cnt_s      = cnt_r;
        hi_s       = hi_r;
        lo_s       = lo_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        dz_s       = dz_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s    = CALC;
                    busy_s     = 1'b1;
                    is_div_s   = bus.MDControl[1];
                    sign_q_s   = sa_s ^ sb_s;
                    sign_rem_s = sa_s;
                    a_raw_s    = bus.SrcA;
                    op_s       = bus.MDControl[1] ? b_mag_s : a_mag_s;
                    acc_s      = {{width{1'b0}}, (bus.MDControl[1] ? a_mag_s : b_mag_s)};
                    cnt_s      = {CW{1'b0}};
                    dz_s       = bus.MDControl[1] && (bus.SrcB == {width{1'b0}});
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (is_div_r) begin
                    if (div_ge_s) begin
                        acc_s = {div_diff_s, acc_r[width-2:0], 1'b1};
                    end else begin
                        acc_s = {div_shift_s[width-1:0], acc_r[width-2:0], 1'b0};
                    end
                end else begin
                    acc_s = {mul_sum_s, acc_r[width-1:1]};
                end
                cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_r == LAST_STEP) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                if (!is_div_r) begin
                    {hi_s, lo_s} = sign_q_r ? neg_2w(acc_r) : acc_r;
                end else if (dz_r) begin
                    hi_s = a_raw_r;
                    lo_s = {width{1'b1}};
                end else begin
                    lo_s = sign_q_r   ? neg_w(acc_r[width-1:0])       : acc_r[width-1:0];
                    hi_s = sign_rem_r ? neg_w(acc_r[2*width-1:width]) : acc_r[2*width-1:width];
                end
                busy_s  = 1'b0;
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            is_div_r   <= 1'b0;
            sign_q_r   <= 1'b0;
            sign_rem_r <= 1'b0;
            op_r       <= {width{1'b0}};
            a_raw_r    <= {width{1'b0}};
            acc_r      <= {(2*width){1'b0}};
            cnt_r      <= {CW{1'b0}};
            hi_r       <= {width{1'b0}};
            lo_r       <= {width{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dz_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            is_div_r   <= is_div_s;
            sign_q_r   <= sign_q_s;
            sign_rem_r <= sign_rem_s;
            op_r       <= op_s;
            a_raw_r    <= a_raw_s;
            acc_r      <= acc_s;
            cnt_r      <= cnt_s;
            hi_r       <= hi_s;
            lo_r       <= lo_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            dz_r       <= dz_s;
        end
    end

    assign bus.HI       = hi_r;
    assign bus.LO       = lo_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: hand-derived vector table, random vectors against a
// behavioural model, a result scoreboard, and sequences for ignored starts and mid-run reset.
module tb_mult_div_unit;
    localparam int W = 32;

    typedef struct {
        logic [1:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    vec_t vecs[14];

    mult_div_unit_if #(.width(W)) bus_if ();

    mult_div_unit #(.width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic model(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        logic signed [2*W-1:0] sp;
        logic [2*W-1:0]        up;
        dz = 1'b0;
        hi = 32'h0;
        lo = 32'h0;
        case (c)
            2'b00: begin
                up = {32'h0, a} * {32'h0, b};
                hi = up[2*W-1:W];
                lo = up[W-1:0];
            end
            2'b01: begin
                sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                hi = sp[2*W-1:W];
                lo = sp[W-1:0];
            end
            default: begin
                if (b == 32'h0) begin
                    dz = 1'b1;
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (c == 2'b10) begin
                    lo = a / b;
                    hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'h0;
                end else begin
                    lo = $signed(a) / $signed(b);
                    hi = $signed(a) % $signed(b);
                end
            end
        endcase
    endtask

    // Starts an operation in the current cycle and waits for its done pulse; optionally
    // pulses start at cycles 5 and 20 of the run with unrelated operands.
    task automatic run_op(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz,
                          input bit noise);
        int   cycles;
        exp_t e;
        bus_if.start     = 1'b1;
        bus_if.MDControl = c;
        bus_if.SrcA      = a;
        bus_if.SrcB      = b;
        exp_q.push_back('{hi: hi, lo: lo, dz: dz});
        tick();
        bus_if.start     = 1'b0;
        bus_if.MDControl = 2'($urandom_range(0, 3));
        bus_if.SrcA      = $urandom;
        bus_if.SrcB      = $urandom;
        check("busy_after_start", 32'(bus_if.busy), 32'h1);
        check("div_zero_at_start", 32'(bus_if.div_zero), 32'(dz));
        cycles = 0;
        do begin
            bus_if.start = noise && (cycles == 5 || cycles == 20);
            tick();
            cycles++;
        end while (!bus_if.done && cycles < 60);
        bus_if.start = 1'b0;
        check("latency", 32'(cycles), 32'd33);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue, expected one pending result");
        end else begin
            e = exp_q.pop_front();
            if (bus_if.done) begin
                check("HI", bus_if.HI, e.hi);
                check("LO", bus_if.LO, e.lo);
                check("div_zero", 32'(bus_if.div_zero), 32'(e.dz));
                check("busy_at_done", 32'(bus_if.busy), 32'h0);
            end
        end
    endtask

    initial begin
        logic [1:0]   rc;
        logic [W-1:0] ra, rb, rhi, rlo;
        logic         rdz;
        int           done_cnt;

        checks = 0;
        errors = 0;
        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2]  = '{2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0010, 1'b0};
        vecs[3]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[5]  = '{2'b10, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[7]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[8]  = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
        vecs[9]  = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{2'b10, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};
        vecs[11] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[12] = '{2'b10, 32'd3,         32'd10,        32'd3,         32'd0,         1'b0};
        vecs[13] = '{2'b01, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};

        rst_n            = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.MDControl = 2'b00;
        bus_if.SrcA      = 32'h0;
        bus_if.SrcB      = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_HI", bus_if.HI, 32'h0);
        check("reset_LO", bus_if.LO, 32'h0);
        check("reset_busy", 32'(bus_if.busy), 32'h0);
        check("reset_done", 32'(bus_if.done), 32'h0);
        check("reset_div_zero", 32'(bus_if.div_zero), 32'h0);

        // Table vectors run back to back: each start lands in the previous done cycle
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b0);
        end

        for (int i = 0; i < 3; i++) tick();
        check("hold_HI", bus_if.HI, vecs[13].hi);
        check("hold_LO", bus_if.LO, vecs[13].lo);
        check("hold_done", 32'(bus_if.done), 32'h0);

        run_op(vecs[3].ctrl, vecs[3].a, vecs[3].b, vecs[3].hi, vecs[3].lo, vecs[3].dz, 1'b1);
        run_op(vecs[0].ctrl, vecs[0].a, vecs[0].b, vecs[0].hi, vecs[0].lo, vecs[0].dz, 1'b1);

        for (int i = 0; i < 10; i++) begin
            rc = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'($urandom_range(0, 15)) : $urandom;
            model(rc, ra, rb, rhi, rlo, rdz);
            run_op(rc, ra, rb, rhi, rlo, rdz, 1'b0);
        end

        // Reset in the middle of a divide by zero: flag, HI/LO and handshake all clear
        tick();
        bus_if.start     = 1'b1;
        bus_if.MDControl = 2'b11;
        bus_if.SrcA      = 32'hFFFF_FF00;
        bus_if.SrcB      = 32'h0;
        tick();
        bus_if.start = 1'b0;
        check("dz_before_reset", 32'(bus_if.div_zero), 32'h1);
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("midrst_busy", 32'(bus_if.busy), 32'h0);
        check("midrst_done", 32'(bus_if.done), 32'h0);
        check("midrst_HI", bus_if.HI, 32'h0);
        check("midrst_LO", bus_if.LO, 32'h0);
        check("midrst_div_zero", 32'(bus_if.div_zero), 32'h0);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_if.done) done_cnt++;
        end
        check("no_done_after_reset", 32'(done_cnt), 32'h0);
        check("idle_after_reset", 32'(bus_if.busy), 32'h0);

        run_op(vecs[4].ctrl, vecs[4].a, vecs[4].b, vecs[4].hi, vecs[4].lo, vecs[4].dz, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
